// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes,
// FSM state encoding, iteration count and an operand magnitude helper.
package muldiv_pkg;

    // Operation encodings presented on the op port.
    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    // FSM state encoding.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // One iteration per operand bit.
    localparam int ITER_COUNT = 32;

    // Two's-complement magnitude for signed operands, raw value otherwise.
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit producing HI/LO results.
// Magnitudes are processed in a shared 64-bit working register over 32
// cycles; signs are recorded at start and applied when the result is written.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

    logic [1:0]  state_q,   state_d;
    logic [63:0] work_q,    work_d;
    logic [31:0] opnd_q,    opnd_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        op_div_q,  op_div_d;
    logic        neg_q,     neg_d;      // negate product / quotient
    logic        rem_neg_q, rem_neg_d;  // negate remainder (dividend sign)
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;

    logic        in_signed;
    logic        a_neg;
    logic        b_neg;
    logic [32:0] mul_sum;
    logic [32:0] div_rem;
    logic [32:0] div_diff;
    logic [63:0] step_work;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand sign decode plus one multiply or divide iteration and the sign fix-up.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & a[31];
        b_neg     = in_signed & b[31];

        // Shift-add: multiplier magnitude sits in the low half, partial
        // product accumulates in the high half; the carry shifts back in.
        mul_sum = {1'b0, work_q[63:32]};
        if (work_q[0]) begin
            mul_sum = {1'b0, work_q[63:32]} + {1'b0, opnd_q};
        end

        // Restoring divide: the partial remainder shifted left needs 33 bits
        // before the trial subtraction.
        div_rem  = work_q[63:31];
        div_diff = div_rem - {1'b0, opnd_q};

        if (op_div_q) begin
            if (!div_diff[32]) begin
                step_work = {div_diff[31:0], work_q[30:0], 1'b1};
            end else begin
                step_work = {div_rem[31:0], work_q[30:0], 1'b0};
            end
        end else begin
            step_work = {mul_sum, work_q[31:1]};
        end

        prod_fix = neg_q     ? (64'd0 - step_work)       : step_work;
        quo_fix  = neg_q     ? (32'd0 - step_work[31:0])  : step_work[31:0];
        rem_fix  = rem_neg_q ? (32'd0 - step_work[63:32]) : step_work[63:32];
    end

    // FSM next-state and register update selection.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_div_d = op[1];
                    cnt_d    = 5'd0;
                    state_d  = CALC;
                    if (op[1]) begin
                        work_d    = {32'd0, mag32(a, in_signed)};
                        opnd_d    = mag32(b, in_signed);
                        // A zero divisor must leave the all-ones quotient
                        // untouched; the remainder still follows the dividend.
                        neg_d     = (a_neg ^ b_neg) & (b != 32'd0);
                        rem_neg_d = a_neg;
                    end else begin
                        work_d    = {32'd0, mag32(b, in_signed)};
                        opnd_d    = mag32(a, in_signed);
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = 1'b0;
                    end
                end
            end
            CALC: begin
                work_d = step_work;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    hi_d    = op_div_q ? rem_fix : prod_fix[63:32];
                    lo_d    = op_div_q ? quo_fix : prod_fix[31:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that also clears the result.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= 64'd0;
            opnd_q    <= 32'd0;
            cnt_q     <= 5'd0;
            op_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
